// File: rtl/grid_click_detector.sv
// Grid click detector: on a rising edge of the left mouse button, finds which
// card of a ROWS x COLS grid the cursor is over, reads that card's state from
// an external register file and pulses event_occurred if the card is clickable.
// Card rectangles are walked one per cycle using running accumulators, so the
// block needs no multipliers or dividers.
module grid_click_detector #(
    parameter int COLS      = 4,
    parameter int ROWS      = 4,
    parameter int X_START   = 32,
    parameter int Y_START   = 40,
    parameter int CARD_W    = 200,
    parameter int CARD_H    = 150,
    parameter int GAP_X     = 40,
    parameter int GAP_Y     = 30,
    parameter int STATE_W   = 2,
    parameter int CLICKABLE = 0,
    parameter int ADDR_W    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               left,
    input  logic [11:0]        mouse_xpos,
    input  logic [11:0]        mouse_ypos,
    input  logic [STATE_W-1:0] card_state,
    output logic [ADDR_W-1:0]  card_rd_address,
    output logic [ADDR_W-1:0]  card_clicked_address,
    output logic               event_occurred,
    output logic               busy
);

    localparam int NCARDS = ROWS * COLS;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    // Wide enough that start + pitch + card size never wraps for any sane grid
    localparam int ACC_W  = 16;

    localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(NCARDS - 1);
    localparam logic [COL_W-1:0]   LAST_COL    = COL_W'(COLS - 1);
    localparam logic [ACC_W-1:0]   X_ORIGIN    = ACC_W'(X_START);
    localparam logic [ACC_W-1:0]   Y_ORIGIN    = ACC_W'(Y_START);
    localparam logic [ACC_W-1:0]   PITCH_X     = ACC_W'(CARD_W + GAP_X);
    localparam logic [ACC_W-1:0]   PITCH_Y     = ACC_W'(CARD_H + GAP_Y);
    localparam logic [ACC_W-1:0]   SIZE_X      = ACC_W'(CARD_W);
    localparam logic [ACC_W-1:0]   SIZE_Y      = ACC_W'(CARD_H);
    localparam logic [ACC_W-1:0]   SCREEN_LIM  = ACC_W'(4096);
    localparam logic [STATE_W-1:0] CLICK_VALUE = STATE_W'(CLICKABLE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOCATE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]        r_state;
    logic              r_left_prev;
    logic [11:0]       r_x;
    logic [11:0]       r_y;
    logic [ADDR_W-1:0] r_idx;
    logic [COL_W-1:0]  r_col;
    logic [ACC_W-1:0]  r_x_lo;
    logic [ACC_W-1:0]  r_y_lo;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_clicked_addr;

    logic              w_trigger;
    logic [ACC_W-1:0]  w_x_hi;
    logic [ACC_W-1:0]  w_y_hi;
    logic [ACC_W-1:0]  w_x;
    logic [ACC_W-1:0]  w_y;
    logic              w_hit;
    logic              w_last_idx;
    logic              w_last_col;

    assign w_trigger  = left & ~r_left_prev & enable & (r_state == S_IDLE);
    assign w_x        = ACC_W'(r_x);
    assign w_y        = ACC_W'(r_y);
    assign w_x_hi     = r_x_lo + SIZE_X;
    assign w_y_hi     = r_y_lo + SIZE_Y;
    // Half-open rectangle test; a card reaching past pixel 4095 can never hit
    assign w_hit      = (w_x >= r_x_lo) && (w_x < w_x_hi) &&
                        (w_y >= r_y_lo) && (w_y < w_y_hi) &&
                        (w_x_hi <= SCREEN_LIM) && (w_y_hi <= SCREEN_LIM);
    assign w_last_idx = (r_idx == LAST_IDX);
    assign w_last_col = (r_col == LAST_COL);

    assign card_rd_address      = r_rd_addr;
    assign card_clicked_address = r_clicked_addr;
    assign event_occurred       = (r_state == S_REPORT);
    assign busy                 = (r_state != S_IDLE);

    // Track the previous level of left in every state for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left_prev <= 1'b0;
        end else begin
            r_left_prev <= left;
        end
    end

    // Control FSM with the card-walking accumulators and address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_x            <= '0;
            r_y            <= '0;
            r_idx          <= '0;
            r_col          <= '0;
            r_x_lo         <= '0;
            r_y_lo         <= '0;
            r_rd_addr      <= '0;
            r_clicked_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state <= S_LOCATE;
                        r_x     <= mouse_xpos;
                        r_y     <= mouse_ypos;
                        r_idx   <= '0;
                        r_col   <= '0;
                        r_x_lo  <= X_ORIGIN;
                        r_y_lo  <= Y_ORIGIN;
                    end
                end
                S_LOCATE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        r_state   <= S_READ;
                        r_rd_addr <= r_idx;
                    end else if (w_last_idx) begin
                        r_state <= S_IDLE;
                    end else begin
                        // Row-major walk: step right, wrap to the next row start
                        r_idx <= r_idx + 1'b1;
                        if (w_last_col) begin
                            r_col  <= '0;
                            r_x_lo <= X_ORIGIN;
                            r_y_lo <= r_y_lo + PITCH_Y;
                        end else begin
                            r_col  <= r_col + 1'b1;
                            r_x_lo <= r_x_lo + PITCH_X;
                        end
                    end
                end
                S_READ: begin
                    // Register file answers one cycle after the address
                    r_state <= enable ? S_CHECK : S_IDLE;
                end
                S_CHECK: begin
                    if (enable && (card_state == CLICK_VALUE)) begin
                        r_state        <= S_REPORT;
                        r_clicked_addr <= r_rd_addr;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_click_detector.sv
// Bench for grid_click_detector: directed clicks on the corner cases followed
// by randomized clicks, all compared against a geometric reference model.
module tb_grid_click_detector;

    localparam int COLS    = 4;
    localparam int ROWS    = 4;
    localparam int X_START = 32;
    localparam int Y_START = 40;
    localparam int CARD_W  = 200;
    localparam int CARD_H  = 150;
    localparam int GAP_X   = 40;
    localparam int GAP_Y   = 30;
    localparam int NCARDS  = ROWS * COLS;
    localparam int WIN     = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [1:0]  card_state;
    logic [3:0]  card_rd_address;
    logic [3:0]  card_clicked_address;
    logic        event_occurred;
    logic        busy;

    logic [1:0]  states [NCARDS];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_clicked = 0;
    int          exp_rd      = 0;

    // clock / reset
    always #5 clk = ~clk;

    // Register file model with one cycle of read latency
    always @(posedge clk) card_state <= states[card_rd_address];

    grid_click_detector dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .left                 (left),
        .mouse_xpos           (mouse_xpos),
        .mouse_ypos           (mouse_ypos),
        .card_state           (card_state),
        .card_rd_address      (card_rd_address),
        .card_clicked_address (card_clicked_address),
        .event_occurred       (event_occurred),
        .busy                 (busy)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: which card contains (x,y), straight from the layout formula
    function automatic int model_hit(input int x, input int y);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int x0 = X_START + c * (CARD_W + GAP_X);
                int y0 = Y_START + r * (CARD_H + GAP_Y);
                if (x0 + CARD_W > 4096 || y0 + CARD_H > 4096) continue;
                if (x >= x0 && x < x0 + CARD_W && y >= y0 && y < y0 + CARD_H)
                    return r * COLS + c;
            end
        end
        return -1;
    endfunction

    // Driver: one click, then observe WIN cycles. Observation n is taken
    // mid-period after edge n (edge 0 samples the trigger), so it is the
    // value edge n+1 sees; a hit on k must pulse at observation k+3.
    task automatic click(input int x, input int y, input bit toggle,
                         input bit rel_rst, input string tag);
        int k;
        bit acc;
        int exp_busy;
        int pulses;
        int pulse_at;
        int busy_n;
        int rd_read;
        int rd_check;
        k        = model_hit(x, y);
        acc      = (k >= 0) && (states[k] == 2'd0);
        exp_busy = (k < 0) ? NCARDS : (acc ? k + 4 : k + 3);
        pulses   = 0;
        pulse_at = -1;
        busy_n   = 0;
        rd_read  = -1;
        rd_check = -1;
        @(negedge clk);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        left = 1'b1;
        if (rel_rst) rst = 1'b0;
        @(posedge clk);
        for (int n = 0; n < WIN; n++) begin
            @(negedge clk);
            if (event_occurred) begin
                pulses++;
                pulse_at = n;
            end
            if (busy) busy_n++;
            if (k >= 0 && n == k + 1) rd_read = int'(card_rd_address);
            if (k >= 0 && n == k + 2) rd_check = int'(card_rd_address);
            if (n == 0) begin
                mouse_xpos = 12'($urandom_range(0, 4095));
                mouse_ypos = 12'($urandom_range(0, 4095));
            end
            if (toggle && n == 1) left = 1'b0;
            if (toggle && n == 2) left = 1'b1;
        end
        left = 1'b0;
        check_eq({tag, " pulses"}, pulses, acc ? 1 : 0);
        if (acc) begin
            check_eq({tag, " pulse_cycle"}, pulse_at, k + 3);
            exp_clicked = k;
        end
        if (k >= 0) begin
            exp_rd = k;
            check_eq({tag, " rd_addr_read"}, rd_read, k);
            check_eq({tag, " rd_addr_check"}, rd_check, k);
        end
        check_eq({tag, " busy_cycles"}, busy_n, exp_busy);
        check_eq({tag, " clicked_addr"}, int'(card_clicked_address), exp_clicked);
        check_eq({tag, " rd_addr_hold"}, int'(card_rd_address), exp_rd);
    endtask

    // Start a click aimed at card 15 so the FSM is still walking in LOCATE
    task automatic start_far_click();
        @(negedge clk);
        mouse_xpos = 12'd800;
        mouse_ypos = 12'd600;
        left = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int r;
        int c;
        int x;
        int y;
        rst = 1'b1;
        enable = 1'b1;
        left = 1'b0;
        mouse_xpos = '0;
        mouse_ypos = '0;
        for (int i = 0; i < NCARDS; i++) states[i] = 2'd0;
        #2;
        check_eq("reset busy", int'(busy), 0);
        check_eq("reset event", int'(event_occurred), 0);
        check_eq("reset rd_addr", int'(card_rd_address), 0);
        check_eq("reset clicked_addr", int'(card_clicked_address), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed clicks
        click(100, 100, 1'b0, 1'b0, "card0");
        click(300, 250, 1'b0, 1'b0, "card5");
        click(240, 100, 1'b0, 1'b0, "gap");
        click(1000, 700, 1'b0, 1'b0, "outside");
        states[5] = 2'd1;
        click(300, 250, 1'b0, 1'b0, "card5_locked");
        states[5] = 2'd0;
        click(100, 100, 1'b1, 1'b0, "toggle_busy");
        click(800, 600, 1'b0, 1'b0, "card15");

        // enable dropped in LOCATE
        start_far_click();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_eq("en_drop busy", int'(busy), 0);
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (event_occurred) pulses++;
        end
        check_eq("en_drop pulses", pulses, 0);
        check_eq("en_drop clicked_addr", int'(card_clicked_address), exp_clicked);
        enable = 1'b1;
        left = 1'b0;
        click(100, 100, 1'b0, 1'b0, "after_en");

        // rst pulsed in LOCATE, left still held when rst is released
        start_far_click();
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst busy", int'(busy), 0);
        check_eq("async_rst clicked_addr", int'(card_clicked_address), 0);
        check_eq("async_rst rd_addr", int'(card_rd_address), 0);
        exp_clicked = 0;
        exp_rd = 0;
        @(negedge clk);
        click(300, 250, 1'b0, 1'b1, "after_rst");

        // Randomized clicks
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NCARDS; i++) states[i] = 2'($urandom_range(0, 3) == 0 ? 1 : 0);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, ROWS - 1);
                c = $urandom_range(0, COLS - 1);
                x = X_START + c * (CARD_W + GAP_X) + $urandom_range(0, CARD_W - 1);
                y = Y_START + r * (CARD_H + GAP_Y) + $urandom_range(0, CARD_H - 1);
            end else begin
                x = $urandom_range(0, 1100);
                y = $urandom_range(0, 800);
            end
            click(x, y, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
